// File: rtl/if_id_fetch_stage_if.sv
// Bundle between the fetch stage, the hazard unit, instruction memory and decode.
// The fetch stage is the master; its peers see the slave view.
interface if_id_fetch_stage_if #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 stall;
    logic                 flush;
    logic [WIDTH-1:0]     branch_target;
    logic [WIDTH-1:0]     imem_addr;
    logic [WIDTH-1:0]     imem_data;
    logic [WIDTH-1:0]     ifid_inst;
    logic [WIDTH-1:0]     ifid_pc;
    logic [WIDTH-1:0]     ifid_pc_next;
    logic                 ifid_valid;
    logic [CNT_WIDTH-1:0] stall_count;
    logic [CNT_WIDTH-1:0] flush_count;

    modport master (
        input  stall, flush, branch_target, imem_data,
        output imem_addr, ifid_inst, ifid_pc, ifid_pc_next, ifid_valid,
               stall_count, flush_count
    );

    modport slave (
        output stall, flush, branch_target, imem_data,
        input  imem_addr, ifid_inst, ifid_pc, ifid_pc_next, ifid_valid,
               stall_count, flush_count
    );
endinterface

// File: rtl/if_id_fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register and saturating
// stall/flush debug counters. Priority per edge: flush > stall > advance.
module if_id_fetch_stage #(
    parameter int unsigned           WIDTH     = 16,
    parameter int unsigned           PC_STEP   = 2,
    parameter logic [WIDTH-1:0]      RESET_PC  = '0,
    parameter logic [WIDTH-1:0]      NOP_INST  = '0,
    parameter int unsigned           CNT_WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    if_id_fetch_stage_if.master bus
);
    logic [WIDTH-1:0]     pc_q, pc_d;
    logic [WIDTH-1:0]     ifid_inst_q, ifid_inst_d;
    logic [WIDTH-1:0]     ifid_pc_q, ifid_pc_d;
    logic [WIDTH-1:0]     ifid_pc_next_q, ifid_pc_next_d;
    logic                 ifid_valid_q, ifid_valid_d;
    logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
    logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;
    logic [WIDTH-1:0]     pc_plus;

    assign pc_plus = pc_q + WIDTH'(PC_STEP);

    always_comb begin
        pc_d           = pc_q;
        ifid_inst_d    = ifid_inst_q;
        ifid_pc_d      = ifid_pc_q;
        ifid_pc_next_d = ifid_pc_next_q;
        ifid_valid_d   = ifid_valid_q;
        stall_count_d  = stall_count_q;
        flush_count_d  = flush_count_q;

        if (bus.flush) begin
            // ifid_pc/ifid_pc_next deliberately hold across the bubble
            pc_d         = bus.branch_target;
            ifid_inst_d  = NOP_INST;
            ifid_valid_d = 1'b0;
            if (flush_count_q != '1) flush_count_d = flush_count_q + CNT_WIDTH'(1);
        end else if (!bus.stall) begin
            if (stall_count_q != '1) stall_count_d = stall_count_q + CNT_WIDTH'(1);
        end else begin
            pc_d           = pc_plus;
            ifid_inst_d    = bus.imem_data;
            ifid_pc_d      = pc_q;
            ifid_pc_next_d = pc_plus;
            ifid_valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q           <= RESET_PC;
            ifid_inst_q    <= NOP_INST;
            ifid_pc_q      <= '0;
            ifid_pc_next_q <= '0;
            ifid_valid_q   <= 1'b0;
            stall_count_q  <= '0;
            flush_count_q  <= '0;
        end else begin
            pc_q           <= pc_d;
            ifid_inst_q    <= ifid_inst_d;
            ifid_pc_q      <= ifid_pc_d;
            ifid_pc_next_q <= ifid_pc_next_d;
            ifid_valid_q   <= ifid_valid_d;
            stall_count_q  <= stall_count_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign bus.imem_addr    = pc_q;
    assign bus.ifid_inst    = ifid_inst_q;
    assign bus.ifid_pc      = ifid_pc_q;
    assign bus.ifid_pc_next = ifid_pc_next_q;
    assign bus.ifid_valid   = ifid_valid_q;
    assign bus.stall_count  = stall_count_q;
    assign bus.flush_count  = flush_count_q;
endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Self-checking bench for if_id_fetch_stage: directed scenarios plus random
// stall/flush traffic against a behavioural pipeline model.
module tb_if_id_fetch_stage;
    logic clock = 1'b0;
    logic reset;

    if_id_fetch_stage_if #(.WIDTH(16), .CNT_WIDTH(8)) bus ();

    if_id_fetch_stage #(
        .WIDTH    (16),
        .PC_STEP  (2),
        .RESET_PC (16'h0000),
        .NOP_INST (16'h0000),
        .CNT_WIDTH(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Instruction memory: each word is its address XOR A5A5
    assign bus.imem_data = bus.imem_addr ^ 16'hA5A5;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference state
    logic [15:0] m_pc, m_inst, m_ifpc, m_ifpcn;
    logic        m_valid;
    int unsigned m_sc, m_fc;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_inst = 16'h0000; m_ifpc = 16'h0000; m_ifpcn = 16'h0000;
        m_valid = 1'b0; m_sc = 0; m_fc = 0;
    endtask

    task automatic model_edge(input logic st, input logic fl, input logic [15:0] bt);
        if (fl) begin
            m_pc = bt; m_inst = 16'h0000; m_valid = 1'b0;
            if (m_fc < 255) m_fc++;
        end else if (!st) begin
            if (m_sc < 255) m_sc++;
        end else begin
            m_inst  = m_pc ^ 16'hA5A5;
            m_ifpc  = m_pc;
            m_ifpcn = 16'(m_pc + 16'd2);
            m_valid = 1'b1;
            m_pc    = 16'(m_pc + 16'd2);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".addr"},  32'(bus.imem_addr),    32'(m_pc));
        check_eq({tag, ".inst"},  32'(bus.ifid_inst),    32'(m_inst));
        check_eq({tag, ".ifpc"},  32'(bus.ifid_pc),      32'(m_ifpc));
        check_eq({tag, ".ifpcn"}, 32'(bus.ifid_pc_next), 32'(m_ifpcn));
        check_eq({tag, ".valid"}, 32'(bus.ifid_valid),   32'(m_valid));
        check_eq({tag, ".scnt"},  32'(bus.stall_count),  m_sc);
        check_eq({tag, ".fcnt"},  32'(bus.flush_count),  m_fc);
    endtask

    task automatic step(input string tag, input logic st, input logic fl, input logic [15:0] bt);
        @(negedge clock);
        bus.stall = st; bus.flush = fl; bus.branch_target = bt;
        @(posedge clock);
        model_edge(st, fl, bt);
        #1 check_all(tag);
    endtask

    initial begin
        reset = 1'b1;
        bus.stall = 1'b1; bus.flush = 1'b0; bus.branch_target = 16'h0000;
        model_reset();
        repeat (2) @(posedge clock);
        #1 check_all("reset");
        #1 reset = 1'b0;

        // Sequential fetch 0,2,4 -> A5A5, A5A7, A5A1
        step("fetch0", 1'b1, 1'b0, 16'h0);
        check_eq("fetch0.lit", 32'(bus.ifid_inst), 32'h0000A5A5);
        step("fetch1", 1'b1, 1'b0, 16'h0);
        step("fetch2", 1'b1, 1'b0, 16'h0);
        check_eq("fetch2.lit", 32'(bus.ifid_inst), 32'h0000A5A1);

        // Stall three cycles at pc=6, then capture pc=6
        repeat (3) step("stall", 1'b0, 1'b0, 16'h0);
        check_eq("stall.cnt3", 32'(bus.stall_count), 32'd3);
        step("unstall", 1'b1, 1'b0, 16'h0);
        check_eq("unstall.pc6", 32'(bus.ifid_pc), 32'h6);

        // Flush with simultaneous stall at pc=8
        step("flush", 1'b0, 1'b1, 16'h0040);
        check_eq("flush.addr", 32'(bus.imem_addr), 32'h40);
        step("postflush", 1'b1, 1'b0, 16'h0);
        check_eq("postflush.inst", 32'(bus.ifid_inst), 32'(16'h0040 ^ 16'hA5A5));

        // Back-to-back flushes then wrap-around at FFFE
        step("flush2a", 1'b1, 1'b1, 16'h1234);
        step("flush2b", 1'b1, 1'b1, 16'hFFFE);
        step("wrap0", 1'b1, 1'b0, 16'h0);
        check_eq("wrap0.pcn", 32'(bus.ifid_pc_next), 32'h0);
        step("wrap1", 1'b1, 1'b0, 16'h0);
        check_eq("wrap1.addr", 32'(bus.imem_addr), 32'h2);

        // Stall counter saturation
        repeat (300) step("sat", 1'b0, 1'b0, 16'h0);
        check_eq("sat.cnt", 32'(bus.stall_count), 32'd255);

        // Random traffic, including unaligned branch targets
        for (int i = 0; i < 300; i++) begin
            logic st, fl;
            logic [15:0] bt;
            st = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 7) == 0);
            bt = 16'($urandom);
            step("rand", st, fl, bt);
            check_eq("rand.xfree", 32'($isunknown({bus.imem_addr, bus.ifid_inst, bus.ifid_pc,
                     bus.ifid_pc_next, bus.ifid_valid, bus.stall_count, bus.flush_count})), 32'd0);
        end

        // Asynchronous reset between edges during a stall
        step("prerst", 1'b0, 1'b0, 16'h0);
        #2 reset = 1'b1;
        model_reset();
        #1 check_all("asyncrst");
        @(posedge clock);
        #1 check_all("rsthold");
        #1 reset = 1'b0;
        step("rstfetch", 1'b1, 1'b0, 16'h0);
        check_eq("rstfetch.ifpc", 32'(bus.ifid_pc), 32'h0);
        check_eq("rstfetch.inst", 32'(bus.ifid_inst), 32'h0000A5A5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the hazard detection logic.
- Holds the PC, drives the instruction memory address and captures the fetched instruction into IF/ID.
- Consumes the hazard unit's active-low stall and active-high flush to hold the pipeline or redirect it to a branch target.
- Keeps saturating stall/flush event counters for debug.

Parameters:
- WIDTH, 16, PC and instruction width in bits.
- PC_STEP, 2, PC increment per sequential fetch.
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INST, 16'h0000, instruction inserted into IF/ID as a bubble.
- CNT_WIDTH, 8, width of each event counter.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  from hazard unit; 0 = stall (hold), 1 = proceed.
- flush  input  1  from hazard unit; 1 = discard fetch and redirect PC.
- branch_target  input  WIDTH  redirect address, sampled when flush=1.
- imem_addr  output  WIDTH  instruction memory address; always equals pc.
- imem_data  input  WIDTH  instruction at imem_addr; combinational, same cycle.
- ifid_inst  output  WIDTH  registered instruction for decode.
- ifid_pc  output  WIDTH  registered PC of ifid_inst.
- ifid_pc_next  output  WIDTH  registered ifid_pc + PC_STEP.
- ifid_valid  output  1  1 = ifid_inst is a real instruction; 0 = bubble.
- stall_count  output  CNT_WIDTH  saturating count of stall cycles.
- flush_count  output  CNT_WIDTH  saturating count of flush cycles.

Behaviour:
- Reset: clock and reset are as above; reset takes effect immediately, independent of clock. While reset is high:
  - pc = RESET_PC
  - ifid_inst = NOP_INST, ifid_pc = 0, ifid_pc_next = 0, ifid_valid = 0
  - stall_count = 0, flush_count = 0
- imem_addr = pc at all times, including during reset.
- Per rising edge with reset low, priority is flush > stall > advance:
  - Flush (flush=1, stall ignored):
    - pc <= branch_target.
    - IF/ID loads the bubble: ifid_inst <= NOP_INST, ifid_valid <= 0, ifid_pc and ifid_pc_next hold.
    - flush_count increments; stall_count unchanged.
  - Stall (flush=0, stall=0):
    - pc and all IF/ID outputs hold.
    - stall_count increments.
  - Advance (flush=0, stall=1):
    - pc <= pc + PC_STEP.
    - ifid_inst <= imem_data, ifid_pc <= pc, ifid_pc_next <= pc + PC_STEP, ifid_valid <= 1.
- Latency: the instruction at pc appears on ifid_inst one cycle after an advance edge. After a flush, the target instruction reaches IF/ID on the first subsequent advance edge.
- Arithmetic: pc + PC_STEP is truncated to WIDTH bits (modulo 2^WIDTH); a PC of 16'hFFFE advances to 16'h0000. branch_target is used unmodified, with no alignment masking.
- Counters: saturate at all-ones; they do not wrap. Stall and flush in the same cycle increment flush_count only.
- Back-to-back flushes: each one reloads pc from the current branch_target, and IF/ID stays a bubble.
- Reset asserted mid-stall or mid-flush: all state returns to reset values immediately; the first edge after release performs a normal advance from RESET_PC.
- No X on outputs after reset, regardless of stall/flush values.

Test Plan:
- Reset/fetch: hold reset 2 cycles, release with stall=1, flush=0, memory returning addr^16'hA5A5 → imem_addr steps 0,2,4. ifid_inst follows one cycle behind: A5A5, A5A7, A5A1; ifid_valid=1 from the first edge.
- Stall hold: at pc=6, drive stall=0 for 3 cycles → pc stays 6, IF/ID holds the pc=4 entry, stall_count=3. On release, the next edge captures pc=6.
- Flush redirect: at pc=8, pulse flush=1 with branch_target=16'h0040 and stall=0 simultaneously → pc=0x40, ifid_inst=NOP_INST, ifid_valid=0, flush_count=1, stall_count unchanged. The next advance captures the instruction at 0x40 with ifid_valid=1.
- Wrap-around: flush to 16'hFFFE, then advance twice → pc 16'hFFFE → 16'h0000 → 16'h0002; ifid_pc_next for 16'hFFFE is 16'h0000.
- Saturation: CNT_WIDTH=8, hold stall=0 for 300 cycles → stall_count stops at 255 and never wraps.
- Async reset: assert reset between clock edges mid-stall → outputs reach reset values before the next clock edge; the first advance after release fetches RESET_PC.
